cnn_layer_sequencer: RTL and testbench



---
 rtl/cnn_layer_sequencer.sv | 155 +++++++++++++++
 tb/tb_cnn_layer_sequencer.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cnn_layer_sequencer.sv
// Frame-level sequencer for the four-stage CNN layer timer. It walks the stages 1..4 with settle
// gaps between them and a per-stage watchdog, and reports done, err and a frame count.
module cnn_layer_sequencer #(
    parameter int unsigned GAP_CYCLES = 1,
    parameter int unsigned WDOG_W     = 12,
    parameter int unsigned WDOG_LIMIT = 1023,
    parameter int unsigned FCNT_W     = 16
) (
    input  logic              S_AXIS_ACLK,
    input  logic              S_AXIS_ARESET,
    input  logic              start,
    input  logic              abort,
    input  logic              To1,
    input  logic              To2,
    input  logic              To3,
    input  logic              To4,
    output logic              Ti1,
    output logic              Ti2,
    output logic              Ti3,
    output logic              Ti4,
    output logic              start_ready,
    output logic              busy,
    output logic [2:0]        stage,
    output logic              done,
    output logic              err,
    output logic [FCNT_W-1:0] frame_cnt
);

    // Encodings double as the externally visible stage code.
    typedef enum logic [2:0] {
        StIdle = 3'd0,
        StS1   = 3'd1,
        StS2   = 3'd2,
        StS3   = 3'd3,
        StS4   = 3'd4,
        StGap  = 3'd5,
        StDone = 3'd6,
        StErr  = 3'd7
    } state_e;

    localparam logic [WDOG_W-1:0] WdogLast = WDOG_W'(WDOG_LIMIT - 1);
    localparam logic [3:0]        GapLast  = 4'(GAP_CYCLES - 1);

    state_e              state_q, state_d;
    logic [2:0]          nxt_stage_q, nxt_stage_d;
    logic [WDOG_W-1:0]   wdog_q, wdog_d;
    logic [3:0]          gap_q, gap_d;
    logic                err_q, err_d;
    logic [FCNT_W-1:0]   frame_cnt_q, frame_cnt_d;
    logic                stage_to;

    // Only the completion flag of the active stage matters.
    always_comb begin
        stage_to = 1'b0;
        unique case (state_q)
            StS1:    stage_to = To1;
            StS2:    stage_to = To2;
            StS3:    stage_to = To3;
            StS4:    stage_to = To4;
            default: stage_to = 1'b0;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        nxt_stage_d = nxt_stage_q;
        wdog_d      = wdog_q;
        gap_d       = gap_q;
        err_d       = err_q;
        frame_cnt_d = frame_cnt_q;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StS1;
                    err_d   = 1'b0;
                    wdog_d  = '0;
                end
            end
            StS1, StS2, StS3, StS4: begin
                wdog_d = wdog_q + 1'b1;
                if (stage_to) begin
                    // A flag already high on the first stage cycle is left over from before.
                    if (wdog_q == '0) begin
                        state_d = StErr;
                    end else if (state_q == StS4) begin
                        state_d = StDone;
                    end else begin
                        state_d     = StGap;
                        nxt_stage_d = 3'(state_q) + 3'd1;
                        gap_d       = '0;
                    end
                end else if (wdog_q == WdogLast) begin
                    state_d = StErr;
                end
            end
            StGap: begin
                if (gap_q == GapLast) begin
                    state_d = state_e'(nxt_stage_q);
                    wdog_d  = '0;
                end else begin
                    gap_d = gap_q + 4'd1;
                end
            end
            StDone: begin
                state_d     = StIdle;
                frame_cnt_d = frame_cnt_q + 1'b1;
            end
            StErr: begin
                state_d = StIdle;
            end
        endcase

        if (state_d == StErr) begin
            err_d = 1'b1;
        end

        // Abort overrides every other transition and leaves the reported status untouched.
        if (abort) begin
            state_d     = StIdle;
            err_d       = err_q;
            frame_cnt_d = frame_cnt_q;
        end
    end

    always_ff @(posedge S_AXIS_ACLK) begin
        if (S_AXIS_ARESET) begin
            state_q     <= StIdle;
            nxt_stage_q <= 3'd0;
            wdog_q      <= '0;
            gap_q       <= '0;
            err_q       <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            nxt_stage_q <= nxt_stage_d;
            wdog_q      <= wdog_d;
            gap_q       <= gap_d;
            err_q       <= err_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign Ti1         = (state_q == StS1);
    assign Ti2         = (state_q == StS2);
    assign Ti3         = (state_q == StS3);
    assign Ti4         = (state_q == StS4);
    assign start_ready = (state_q == StIdle);
    assign busy        = (state_q != StIdle);
    assign stage       = 3'(state_q);
    assign done        = (state_q == StDone);
    assign err         = err_q;
    assign frame_cnt   = frame_cnt_q;

endmodule

// File: tb/tb_cnn_layer_sequencer.sv
// Directed bench for cnn_layer_sequencer: three instances (default, 2-bit frame count, short
// watchdog) each driven by a threshold timer model with thresholds 38/15/1/285.
module tb_cnn_layer_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [2:0]  rst, start, abort;
    logic [11:0] ti, to, to_zero, to_one;
    logic [2:0]  stage0, stage1, stage2;
    logic [2:0]  ready, busy, done, err;
    logic [15:0] fc0, fc2;
    logic [1:0]  fc1;
    int          cnt [12];
    int          checks = 0;
    int          errors = 0;

    function automatic int thr(int k);
        case (k % 4)
            0:       return 38;
            1:       return 15;
            2:       return 1;
            default: return 285;
        endcase
    endfunction

    // Timer model: per-stage counter runs while Ti is high, flag once it reaches the threshold.
    always @(posedge clk) begin
        for (int i = 0; i < 12; i++) begin
            if (ti[i] !== 1'b1) cnt[i] <= 0;
            else                cnt[i] <= cnt[i] + 1;
        end
    end

    always_comb begin
        to = '0;
        for (int i = 0; i < 12; i++) begin
            to[i] = to_one[i] | (~to_zero[i] & ti[i] & (cnt[i] >= thr(i)));
        end
    end

    cnn_layer_sequencer u_dut0 (
        .S_AXIS_ACLK(clk), .S_AXIS_ARESET(rst[0]), .start(start[0]), .abort(abort[0]),
        .To1(to[0]), .To2(to[1]), .To3(to[2]), .To4(to[3]),
        .Ti1(ti[0]), .Ti2(ti[1]), .Ti3(ti[2]), .Ti4(ti[3]),
        .start_ready(ready[0]), .busy(busy[0]), .stage(stage0), .done(done[0]), .err(err[0]),
        .frame_cnt(fc0)
    );

    cnn_layer_sequencer #(.FCNT_W(2)) u_dut1 (
        .S_AXIS_ACLK(clk), .S_AXIS_ARESET(rst[1]), .start(start[1]), .abort(abort[1]),
        .To1(to[4]), .To2(to[5]), .To3(to[6]), .To4(to[7]),
        .Ti1(ti[4]), .Ti2(ti[5]), .Ti3(ti[6]), .Ti4(ti[7]),
        .start_ready(ready[1]), .busy(busy[1]), .stage(stage1), .done(done[1]), .err(err[1]),
        .frame_cnt(fc1)
    );

    // Limit 40 keeps the 39-cycle S1 legal while still catching a stuck S2.
    cnn_layer_sequencer #(.WDOG_LIMIT(40)) u_dut2 (
        .S_AXIS_ACLK(clk), .S_AXIS_ARESET(rst[2]), .start(start[2]), .abort(abort[2]),
        .To1(to[8]), .To2(to[9]), .To3(to[10]), .To4(to[11]),
        .Ti1(ti[8]), .Ti2(ti[9]), .Ti3(ti[10]), .Ti4(ti[11]),
        .start_ready(ready[2]), .busy(busy[2]), .stage(stage2), .done(done[2]), .err(err[2]),
        .frame_cnt(fc2)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [2:0] exp_stage(int c);
        if (c >= 1 && c <= 39) return 3'd1;
        if (c == 40 || c == 57 || c == 60) return 3'd5;
        if (c >= 41 && c <= 56) return 3'd2;
        if (c >= 58 && c <= 59) return 3'd3;
        if (c >= 61 && c <= 346) return 3'd4;
        if (c == 347) return 3'd6;
        return 3'd0;
    endfunction

    function automatic logic [3:0] ti_of(logic [2:0] s);
        case (s)
            3'd1:    return 4'b0001;
            3'd2:    return 4'b0010;
            3'd3:    return 4'b0100;
            3'd4:    return 4'b1000;
            default: return 4'b0000;
        endcase
    endfunction

    // Pulses start on instance 0 and records cycles 1..348 against the nominal timeline.
    task automatic run_nominal(output int bad, output int first_bad, output int done_cyc,
                               output int done_n);
        logic [2:0] e;
        bad = 0; first_bad = -1; done_cyc = -1; done_n = 0;
        start[0] = 1'b1;
        step();
        start[0] = 1'b0;
        for (int c = 1; c <= 348; c++) begin
            e = exp_stage(c);
            if (stage0 !== e || ti[3:0] !== ti_of(e) || done[0] !== (e == 3'd6)) begin
                bad++;
                if (first_bad < 0) first_bad = c;
            end
            if (done[0] === 1'b1) begin
                done_n++;
                done_cyc = c;
            end
            if (c != 348) step();
        end
    endtask

    task automatic test_reset();
        rst = '1; start = '0; abort = '0; to_zero = '0; to_one = '0;
        step();
        step();
        rst = '0;
        step();
        checks++; if (stage0 !== 3'd0) begin errors++; $display("FAIL reset_stage: got %0d expected 0", stage0); end
        checks++; if (ti[3:0] !== 4'b0) begin errors++; $display("FAIL reset_ti: got %b expected 0000", ti[3:0]); end
        checks++; if (ready[0] !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", ready[0]); end
        checks++; if (busy[0] !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy[0]); end
        checks++; if (done[0] !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done[0]); end
        checks++; if (err[0] !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", err[0]); end
        checks++; if (fc0 !== 16'd0) begin errors++; $display("FAIL reset_fcnt: got %0d expected 0", fc0); end
        checks++; if (stage1 !== 3'd0 || stage2 !== 3'd0) begin errors++; $display("FAIL reset_other_stage: got %0d/%0d expected 0/0", stage1, stage2); end
    endtask

    task automatic test_nominal();
        int bad, first_bad, done_cyc, done_n;
        run_nominal(bad, first_bad, done_cyc, done_n);
        checks++; if (bad !== 0) begin errors++; $display("FAIL nominal_timeline: got %0d bad cycles (first at %0d) expected 0", bad, first_bad); end
        checks++; if (done_n !== 1) begin errors++; $display("FAIL nominal_done_count: got %0d expected 1", done_n); end
        checks++; if (done_cyc !== 347) begin errors++; $display("FAIL nominal_done_cycle: got %0d expected 347", done_cyc); end
        checks++; if (fc0 !== 16'd1) begin errors++; $display("FAIL nominal_fcnt: got %0d expected 1", fc0); end
        checks++; if (err[0] !== 1'b0) begin errors++; $display("FAIL nominal_err: got %b expected 0", err[0]); end
        checks++; if (ready[0] !== 1'b1) begin errors++; $display("FAIL nominal_ready_348: got %b expected 1", ready[0]); end
    endtask

    task automatic test_stale_flag();
        to_one[2] = 1'b1;
        start[0] = 1'b1;
        step();
        start[0] = 1'b0;
        repeat (57) step();
        checks++; if (stage0 !== 3'd3 || ti[2] !== 1'b1) begin errors++; $display("FAIL stale_s3_entry: got stage %0d Ti3 %b expected 3/1", stage0, ti[2]); end
        step();
        checks++; if (stage0 !== 3'd7 || ti[3:0] !== 4'b0) begin errors++; $display("FAIL stale_err_state: got stage %0d Ti %b expected 7/0000", stage0, ti[3:0]); end
        checks++; if (err[0] !== 1'b1) begin errors++; $display("FAIL stale_err_flag: got %b expected 1", err[0]); end
        step();
        checks++; if (stage0 !== 3'd0 || err[0] !== 1'b1) begin errors++; $display("FAIL stale_idle: got stage %0d err %b expected 0/1", stage0, err[0]); end
        checks++; if (fc0 !== 16'd1) begin errors++; $display("FAIL stale_fcnt: got %0d expected 1", fc0); end
        to_one[2] = 1'b0;
    endtask

    task automatic test_abort_idle();
        abort[0] = 1'b1;
        start[0] = 1'b1;
        step();
        abort[0] = 1'b0;
        start[0] = 1'b0;
        checks++; if (stage0 !== 3'd0 || ready[0] !== 1'b1) begin errors++; $display("FAIL abort_idle_accept: got stage %0d ready %b expected 0/1", stage0, ready[0]); end
        checks++; if (err[0] !== 1'b1) begin errors++; $display("FAIL abort_idle_err: got %b expected 1", err[0]); end
        step();
        checks++; if (stage0 !== 3'd0) begin errors++; $display("FAIL abort_idle_late: got %0d expected 0", stage0); end
    endtask

    task automatic test_abort_stage();
        int bad;
        bad = 0;
        start[0] = 1'b1;
        step();
        start[0] = 1'b0;
        checks++; if (err[0] !== 1'b0) begin errors++; $display("FAIL abort_err_cleared: got %b expected 0", err[0]); end
        repeat (38) step();
        checks++; if (stage0 !== 3'd1 || to[0] !== 1'b1) begin errors++; $display("FAIL abort_pre_s1: got stage %0d To1 %b expected 1/1", stage0, to[0]); end
        abort[0] = 1'b1;
        step();
        abort[0] = 1'b0;
        checks++; if (stage0 !== 3'd0 || ti[3:0] !== 4'b0 || done[0] !== 1'b0) begin errors++; $display("FAIL abort_to_idle: got stage %0d Ti %b done %b expected 0/0000/0", stage0, ti[3:0], done[0]); end
        for (int c = 0; c < 10; c++) begin
            step();
            if (stage0 !== 3'd0 || done[0] !== 1'b0) bad++;
        end
        checks++; if (bad !== 0) begin errors++; $display("FAIL abort_stays_idle: got %0d bad cycles expected 0", bad); end
        checks++; if (fc0 !== 16'd1 || err[0] !== 1'b0) begin errors++; $display("FAIL abort_status: got fcnt %0d err %b expected 1/0", fc0, err[0]); end
    endtask

    task automatic test_reset_mid_s4();
        int bad, first_bad, done_cyc, done_n;
        start[0] = 1'b1;
        step();
        start[0] = 1'b0;
        repeat (199) step();
        checks++; if (stage0 !== 3'd4) begin errors++; $display("FAIL rst_mid_s4_pre: got %0d expected 4", stage0); end
        rst[0] = 1'b1;
        step();
        rst[0] = 1'b0;
        checks++; if (stage0 !== 3'd0 || ti[3:0] !== 4'b0 || busy[0] !== 1'b0 || ready[0] !== 1'b1) begin errors++; $display("FAIL rst_mid_s4_state: got stage %0d Ti %b busy %b ready %b expected 0/0000/0/1", stage0, ti[3:0], busy[0], ready[0]); end
        checks++; if (fc0 !== 16'd0 || err[0] !== 1'b0 || done[0] !== 1'b0) begin errors++; $display("FAIL rst_mid_s4_status: got fcnt %0d err %b done %b expected 0/0/0", fc0, err[0], done[0]); end
        run_nominal(bad, first_bad, done_cyc, done_n);
        checks++; if (bad !== 0 || done_cyc !== 347) begin errors++; $display("FAIL rst_refresh_frame: got %0d bad (first %0d) done at %0d expected 0 bad done at 347", bad, first_bad, done_cyc); end
        checks++; if (fc0 !== 16'd1) begin errors++; $display("FAIL rst_refresh_fcnt: got %0d expected 1", fc0); end
    endtask

    task automatic test_watchdog();
        to_zero[9] = 1'b1;
        start[2] = 1'b1;
        step();
        start[2] = 1'b0;
        repeat (40) step();
        checks++; if (stage2 !== 3'd2) begin errors++; $display("FAIL wdog_s2_entry_41: got %0d expected 2", stage2); end
        repeat (39) step();
        checks++; if (stage2 !== 3'd2 || err[2] !== 1'b0) begin errors++; $display("FAIL wdog_still_s2_80: got stage %0d err %b expected 2/0", stage2, err[2]); end
        step();
        checks++; if (stage2 !== 3'd7 || ti[11:8] !== 4'b0) begin errors++; $display("FAIL wdog_err_81: got stage %0d Ti %b expected 7/0000", stage2, ti[11:8]); end
        step();
        checks++; if (stage2 !== 3'd0 || err[2] !== 1'b1 || fc2 !== 16'd0) begin errors++; $display("FAIL wdog_idle_82: got stage %0d err %b fcnt %0d expected 0/1/0", stage2, err[2], fc2); end
        to_zero[9] = 1'b0;
        start[2] = 1'b1;
        step();
        start[2] = 1'b0;
        checks++; if (stage2 !== 3'd1 || err[2] !== 1'b0) begin errors++; $display("FAIL wdog_err_clear: got stage %0d err %b expected 1/0", stage2, err[2]); end
        abort[2] = 1'b1;
        step();
        abort[2] = 1'b0;
        checks++; if (stage2 !== 3'd0) begin errors++; $display("FAIL wdog_abort: got %0d expected 0", stage2); end
    endtask

    task automatic test_back_to_back();
        int         entries [5];
        int         n_entries;
        logic [2:0] prev;
        logic [1:0] exp_fc;
        n_entries = 0;
        prev = stage1;
        start[1] = 1'b1;
        step();
        for (int c = 1; c <= 1741; c++) begin
            if (stage1 === 3'd1 && prev !== 3'd1) begin
                if (n_entries < 5) entries[n_entries] = c;
                n_entries++;
            end
            prev = stage1;
            if (c == 1393) start[1] = 1'b0;
            if (c % 348 == 0) begin
                exp_fc = 2'(c / 348);
                checks++; if (fc1 !== exp_fc) begin errors++; $display("FAIL b2b_fcnt_c%0d: got %0d expected %0d", c, fc1, exp_fc); end
            end
            if (c != 1741) step();
        end
        checks++; if (n_entries !== 5) begin errors++; $display("FAIL b2b_entry_count: got %0d expected 5", n_entries); end
        for (int j = 0; j < 5; j++) begin
            if (j < n_entries) begin
                checks++; if (entries[j] !== 1 + 348 * j) begin errors++; $display("FAIL b2b_s1_entry_%0d: got %0d expected %0d", j, entries[j], 1 + 348 * j); end
            end
        end
        checks++; if (stage1 !== 3'd0) begin errors++; $display("FAIL b2b_final_idle: got %0d expected 0", stage1); end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_stale_flag();
        test_abort_idle();
        test_abort_stage();
        test_reset_mid_s4();
        test_watchdog();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
